// File: rtl/cla16_rr_arbiter_pkg.sv
// Shared constants and helpers for arbiters fronting the 16-bit CLA.
package cla16_rr_arbiter_pkg;

    localparam int CLA_W    = 16;
    localparam int NREQ_DEF = 4;
    localparam int ID_W_DEF = 2;

    typedef enum logic {
        StEmpty,
        StFull
    } out_state_e;

    // Low bit of requester i's operand slice in a flattened bus.
    function automatic int cla_lo(input int i);
        return CLA_W * i;
    endfunction

endpackage

// File: rtl/carry_lookahead_adder_16bit.sv
// 16-bit adder: four 4-bit groups with group-level carry lookahead.
module carry_lookahead_adder_16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);

    logic [15:0] g;
    logic [15:0] p;
    logic [15:0] c;
    logic [3:0]  bg;
    logic [3:0]  bp;
    logic [4:0]  bc;
    logic        cr;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin
        bg = '0;
        bp = '0;
        for (int j = 0; j < 4; j++) begin
            bg[j] = g[4*j+3]
                  | (p[4*j+3] & g[4*j+2])
                  | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                  | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
            bp[j] = &p[4*j +: 4];
        end
    end

    assign bc[0] = cin;
    assign bc[1] = bg[0] | (bp[0] & cin);
    assign bc[2] = bg[1] | (bp[1] & bg[0]) | (bp[1] & bp[0] & cin);
    assign bc[3] = bg[2] | (bp[2] & bg[1]) | (bp[2] & bp[1] & bg[0])
                 | (bp[2] & bp[1] & bp[0] & cin);
    assign bc[4] = bg[3] | (bp[3] & bg[2]) | (bp[3] & bp[2] & bg[1])
                 | (bp[3] & bp[2] & bp[1] & bg[0]) | (bp[3] & bp[2] & bp[1] & bp[0] & cin);

    // Bit carries inside each group start from that group's lookahead carry.
    always_comb begin
        c  = '0;
        cr = 1'b0;
        for (int j = 0; j < 4; j++) begin
            cr = bc[j];
            for (int k = 0; k < 4; k++) begin
                c[4*j+k] = cr;
                cr       = g[4*j+k] | (p[4*j+k] & cr);
            end
        end
    end

    assign sum  = p ^ c;
    assign cout = bc[4];

endmodule

// File: rtl/cla16_rr_arbiter_rr_pick.sv
// Round-robin priority encoder: first asserted request at or after ptr, wrapping.
module cla16_rr_arbiter_rr_pick
    import cla16_rr_arbiter_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int ID_W = ID_W_DEF
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    output logic [ID_W-1:0] winner,
    output logic            any
);

    // Scan from the far end so the nearest candidate to ptr is written last.
    always_comb begin
        winner = '0;
        any    = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % NREQ]) begin
                winner = ID_W'((int'(ptr) + k) % NREQ);
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cla16_rr_arbiter.sv
// Round-robin shares one 16-bit CLA among NREQ requesters; result held in a
// single-entry valid/ready output register.
module cla16_rr_arbiter
    import cla16_rr_arbiter_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int ID_W = ID_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [CLA_W*NREQ-1:0] a_in,
    input  logic [CLA_W*NREQ-1:0] b_in,
    input  logic [NREQ-1:0]       cin_in,
    output logic [NREQ-1:0]       gnt,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CLA_W-1:0]      out_sum,
    output logic                  out_cout,
    output logic [ID_W-1:0]       out_id,
    output logic [15:0]           op_count
);

    out_state_e       state_q, state_d;
    logic [CLA_W-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;

    logic [ID_W-1:0]  winner;
    logic             any_req;
    logic             accept;
    logic [CLA_W-1:0] a_sel, b_sel, add_sum;
    logic             cin_sel, add_cout;

    cla16_rr_arbiter_rr_pick #(
        .NREQ(NREQ),
        .ID_W(ID_W)
    ) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .winner(winner),
        .any   (any_req)
    );

    assign out_valid = (state_q == StFull);
    assign accept    = any_req && (!out_valid || out_ready);

    always_comb begin
        a_sel   = '0;
        b_sel   = '0;
        cin_sel = 1'b0;
        gnt     = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (winner == ID_W'(i)) begin
                a_sel   = a_in[cla_lo(i) +: CLA_W];
                b_sel   = b_in[cla_lo(i) +: CLA_W];
                cin_sel = cin_in[i];
                gnt[i]  = accept && !rst;
            end
        end
    end

    carry_lookahead_adder_16bit u_adder (
        .a   (a_sel),
        .b   (b_sel),
        .cin (cin_sel),
        .sum (add_sum),
        .cout(add_cout)
    );

    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        id_d    = id_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            StEmpty: begin
                if (accept) state_d = StFull;
            end
            StFull: begin
                if (!accept && out_ready) state_d = StEmpty;
            end
            default: state_d = StEmpty;
        endcase
        if (accept) begin
            sum_d  = add_sum;
            cout_d = add_cout;
            id_d   = winner;
            cnt_d  = cnt_q + 16'd1;
            ptr_d  = (winner == ID_W'(NREQ - 1)) ? '0 : winner + ID_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StEmpty;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            id_q    <= '0;
            cnt_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
        end
    end

    assign out_sum  = sum_q;
    assign out_cout = cout_q;
    assign out_id   = id_q;
    assign op_count = cnt_q;

endmodule
